// File: rtl/dout_writer.sv
// Transmit side of the multi-lane ADC serial interface: serialises eight samples onto
// four lanes, generating its own drdy frame strobe and dclk bit clock.
module dout_writer #(
   parameter int DCLK_DIV  = 4,
   parameter int DATA_BITS = 24,
   parameter int SLOT_BITS = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [DATA_BITS-1:0] ch1_i,
   input  logic [DATA_BITS-1:0] ch2_i,
   input  logic [DATA_BITS-1:0] ch3_i,
   input  logic [DATA_BITS-1:0] ch4_i,
   input  logic [DATA_BITS-1:0] ch5_i,
   input  logic [DATA_BITS-1:0] ch6_i,
   input  logic [DATA_BITS-1:0] ch7_i,
   input  logic [DATA_BITS-1:0] ch8_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 overrun_o,
   output logic                 drdy_o,
   output logic                 dclk_o,
   output logic                 dout0_o,
   output logic                 dout1_o,
   output logic                 dout2_o,
   output logic                 dout3_o
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int PAD_BITS   = SLOT_BITS - DATA_BITS;
   localparam int CNT_W      = $clog2(DCLK_DIV);
   localparam int BIT_W      = $clog2(FRAME_BITS);

   typedef enum logic [1:0] {IDLE, DRDY, SHIFT} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        period_q, period_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [FRAME_BITS-1:0]   lane_q [4];
   logic [FRAME_BITS-1:0]   lane_d [4];
   logic                    done_q, done_d;
   logic                    overrun_q, overrun_d;
   logic                    period_last;
   logic                    bit_last;

   assign period_last = (period_q == CNT_W'(DCLK_DIV - 1));
   assign bit_last    = (bit_q == BIT_W'(FRAME_BITS - 1));

   // The done cycle still counts as busy, so a start arriving then is an overrun.
   assign busy_o    = (state_q != IDLE) || done_q;
   assign done_o    = done_q;
   assign overrun_o = overrun_q;
   assign drdy_o    = (state_q == DRDY);
   assign dclk_o    = (state_q == SHIFT) && (period_q >= CNT_W'(DCLK_DIV / 2));
   assign dout0_o   = (state_q == SHIFT) && lane_q[0][FRAME_BITS-1];
   assign dout1_o   = (state_q == SHIFT) && lane_q[1][FRAME_BITS-1];
   assign dout2_o   = (state_q == SHIFT) && lane_q[2][FRAME_BITS-1];
   assign dout3_o   = (state_q == SHIFT) && lane_q[3][FRAME_BITS-1];

   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      bit_d     = bit_q;
      lane_d    = lane_q;
      done_d    = 1'b0;
      overrun_d = start_i && busy_o;
      case (state_q)
         IDLE: begin
            if (start_i && !done_q) begin
               lane_d[0] = {ch1_i, {PAD_BITS{1'b0}}, ch5_i, {PAD_BITS{1'b0}}};
               lane_d[1] = {ch2_i, {PAD_BITS{1'b0}}, ch6_i, {PAD_BITS{1'b0}}};
               lane_d[2] = {ch3_i, {PAD_BITS{1'b0}}, ch7_i, {PAD_BITS{1'b0}}};
               lane_d[3] = {ch4_i, {PAD_BITS{1'b0}}, ch8_i, {PAD_BITS{1'b0}}};
               period_d  = '0;
               bit_d     = '0;
               state_d   = DRDY;
            end
         end
         DRDY: begin
            if (period_last) begin
               period_d = '0;
               state_d  = SHIFT;
            end else begin
               period_d = period_q + CNT_W'(1);
            end
         end
         SHIFT: begin
            // Shifting at the end of a period puts the next bit out as dclk falls.
            if (period_last) begin
               period_d = '0;
               for (int i = 0; i < 4; i++) begin
                  lane_d[i] = {lane_q[i][FRAME_BITS-2:0], 1'b0};
               end
               if (bit_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               period_d = period_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         period_q  <= '0;
         bit_q     <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         bit_q     <= bit_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         for (int i = 0; i < 4; i++) begin
            lane_q[i] <= lane_d[i];
         end
      end
   end

endmodule

// File: tb/tb_dout_writer.sv
// Directed self-checking bench for dout_writer: frame timing, lane mapping,
// overrun, back-to-back frames, input stability and mid-frame reset.
module tb_dout_writer;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        start_i = 1'b0;
   logic [23:0] ch [8];
   logic        busy_o, done_o, overrun_o, drdy_o, dclk_o;
   logic        dout0_o, dout1_o, dout2_o, dout3_o;
   logic [3:0]  douts;

   int errors = 0;
   int checks = 0;

   logic [63:0] cap_lane [4];
   int          cap_drdy_n, cap_drdy_first, cap_rise_n;
   int          cap_done_n, cap_done_first, cap_ovr_n, cap_ovr_first;
   logic        cap_busy261, cap_busy262;
   logic [8:0]  cap_snap;

   assign douts = {dout3_o, dout2_o, dout1_o, dout0_o};

   always #5 clk_i = ~clk_i;

   dout_writer #(.DCLK_DIV(4), .DATA_BITS(24), .SLOT_BITS(32)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
      .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
      .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
      .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o),
      .drdy_o(drdy_o), .dclk_o(dclk_o),
      .dout0_o(dout0_o), .dout1_o(dout1_o), .dout2_o(dout2_o), .dout3_o(dout3_o)
   );

   function automatic logic [63:0] exp_lane(input logic [23:0] a, input logic [23:0] b);
      return {a, 8'h00, b, 8'h00};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Requests a frame now and records what appears over the following 262 cycles;
   // k counts cycles after the accept cycle, so done is expected at k=261.
   task automatic capture_frame(input int ovr_at, input int chg_at, input int rst_at);
      logic prev_dclk;
      prev_dclk = 1'b0;
      for (int i = 0; i < 4; i++) cap_lane[i] = '0;
      cap_drdy_n = 0; cap_drdy_first = 0; cap_rise_n = 0;
      cap_done_n = 0; cap_done_first = 0; cap_ovr_n = 0; cap_ovr_first = 0;
      cap_busy261 = 1'b0; cap_busy262 = 1'b1; cap_snap = '1;
      start_i = 1'b1;
      for (int k = 1; k <= 262; k++) begin
         tick();
         start_i = 1'b0;
         if (drdy_o) begin
            cap_drdy_n++;
            if (cap_drdy_first == 0) cap_drdy_first = k;
         end
         if (dclk_o && !prev_dclk) begin
            cap_rise_n++;
            for (int i = 0; i < 4; i++) cap_lane[i] = {cap_lane[i][62:0], douts[i]};
         end
         prev_dclk = dclk_o;
         if (done_o) begin
            cap_done_n++;
            if (cap_done_first == 0) cap_done_first = k;
         end
         if (overrun_o) begin
            cap_ovr_n++;
            if (cap_ovr_first == 0) cap_ovr_first = k;
         end
         if (k == 261) cap_busy261 = busy_o;
         if (k == 262) cap_busy262 = busy_o;
         if (k == ovr_at) start_i = 1'b1;
         if (k == chg_at) ch[0] = 24'h5A5A5A;
         if (k == rst_at) reset_i = 1'b1;
         if (rst_at != 0 && k == rst_at + 1) begin
            cap_snap = {busy_o, done_o, overrun_o, drdy_o, dclk_o, douts};
            reset_i = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      start_i = 1'b1;
      tick();
      tick();
      start_i = 1'b0;
      checks++;
      if ({busy_o, done_o, overrun_o, drdy_o, dclk_o, douts} !== 9'h000) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected 000",
                  {busy_o, done_o, overrun_o, drdy_o, dclk_o, douts});
      end
      reset_i = 1'b0;
      tick();
      checks++;
      if (busy_o !== 1'b0 || drdy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start_during_reset: busy=%b drdy=%b expected 0 0", busy_o, drdy_o);
      end
   endtask

   task automatic test_basic_frame();
      for (int i = 0; i < 8; i++) ch[i] = 24'h000000;
      ch[0] = 24'h800001;
      capture_frame(0, 0, 0);
      checks++;
      if (cap_drdy_n !== 4 || cap_drdy_first !== 1) begin
         errors++;
         $display("[TB] FAIL basic_drdy: got %0d cycles from %0d expected 4 from 1",
                  cap_drdy_n, cap_drdy_first);
      end
      checks++;
      if (cap_rise_n !== 64) begin
         errors++;
         $display("[TB] FAIL basic_rises: got %0d expected 64", cap_rise_n);
      end
      checks++;
      if (cap_lane[0] !== 64'h8000_0100_0000_0000) begin
         errors++;
         $display("[TB] FAIL basic_lane0: got %h expected 8000010000000000", cap_lane[0]);
      end
      checks++;
      if ((cap_lane[1] | cap_lane[2] | cap_lane[3]) !== 64'h0) begin
         errors++;
         $display("[TB] FAIL basic_quiet_lanes: got %h %h %h expected all 0",
                  cap_lane[1], cap_lane[2], cap_lane[3]);
      end
      checks++;
      if (cap_done_first !== 261 || cap_done_n !== 1) begin
         errors++;
         $display("[TB] FAIL basic_done: got cycle %0d count %0d expected 261 count 1",
                  cap_done_first, cap_done_n);
      end
      checks++;
      if (cap_busy261 !== 1'b1 || cap_busy262 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_busy_tail: got %b%b expected 10", cap_busy261, cap_busy262);
      end
   endtask

   task automatic test_lane_mapping();
      logic [23:0] sent [8];
      for (int i = 0; i < 8; i++) ch[i] = 24'h111111 * (i + 1);
      for (int i = 0; i < 8; i++) sent[i] = ch[i];
      capture_frame(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_lane[i] !== exp_lane(sent[i], sent[i+4])) begin
            errors++;
            $display("[TB] FAIL lane_map%0d: got %h expected %h", i, cap_lane[i],
                     exp_lane(sent[i], sent[i+4]));
         end
      end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 8; i++) ch[i] = 24'h000000;
      ch[0] = 24'h800001;
      capture_frame(100, 0, 0);
      checks++;
      if (cap_ovr_first !== 101 || cap_ovr_n !== 1) begin
         errors++;
         $display("[TB] FAIL overrun_pulse: got cycle %0d count %0d expected 101 count 1",
                  cap_ovr_first, cap_ovr_n);
      end
      checks++;
      if (cap_lane[0] !== 64'h8000_0100_0000_0000 || cap_done_n !== 1 || cap_drdy_n !== 4) begin
         errors++;
         $display("[TB] FAIL overrun_frame: got lane0 %h done %0d drdy %0d expected 8000010000000000 1 4",
                  cap_lane[0], cap_done_n, cap_drdy_n);
      end
      for (int k = 0; k < 10; k++) tick();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overrun_dropped: busy got %b expected 0", busy_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] orig;
      for (int i = 0; i < 8; i++) ch[i] = 24'h0F0F0F + 24'(i);
      orig = ch[0];
      capture_frame(0, 0, 0);
      // capture_frame returns in the cycle after done, so this start is back-to-back.
      capture_frame(0, 50, 0);
      checks++;
      if (cap_drdy_first !== 1 || cap_done_first !== 261) begin
         errors++;
         $display("[TB] FAIL b2b_timing: got drdy %0d done %0d expected 1 261",
                  cap_drdy_first, cap_done_first);
      end
      checks++;
      if (cap_lane[0] !== exp_lane(orig, 24'h0F0F13)) begin
         errors++;
         $display("[TB] FAIL input_stability: got %h expected %h", cap_lane[0],
                  exp_lane(orig, 24'h0F0F13));
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 8; i++) ch[i] = 24'hFFFFFF;
      capture_frame(0, 0, 126);
      checks++;
      if (cap_snap !== 9'h000) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got %h expected 000", cap_snap);
      end
      checks++;
      if (cap_done_n !== 0) begin
         errors++;
         $display("[TB] FAIL midreset_nodone: got %0d expected 0", cap_done_n);
      end
      for (int i = 0; i < 8; i++) ch[i] = 24'hC00003 - 24'(i);
      capture_frame(0, 0, 0);
      checks++;
      if (cap_lane[3] !== exp_lane(24'hC00000, 24'hBFFFFC) || cap_done_first !== 261) begin
         errors++;
         $display("[TB] FAIL midreset_recover: got %h done %0d expected %h done 261",
                  cap_lane[3], cap_done_first, exp_lane(24'hC00000, 24'hBFFFFC));
      end
   endtask

   task automatic test_random_frames();
      logic [23:0] sent [8];
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 8; i++) begin
            ch[i] = 24'($urandom);
            sent[i] = ch[i];
         end
         capture_frame(0, 0, 0);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_lane[i][63:40] !== sent[i] || cap_lane[i][31:8] !== sent[i+4] ||
                cap_lane[i][39:32] !== 8'h00 || cap_lane[i][7:0] !== 8'h00) begin
               errors++;
               $display("[TB] FAIL random_lane%0d: got %h expected %h", i, cap_lane[i],
                        exp_lane(sent[i], sent[i+4]));
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) ch[i] = '0;
      test_reset();
      test_basic_frame();
      test_lane_mapping();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
